// File: rtl/cpu_bus_pkg.sv
// Purpose: shared FSM state encoding and default register map for the CPU bus front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_REG1_ADDR   = 1;
  localparam int DEF_REG2_ADDR   = 2;
  localparam int DEF_REG3_ADDR   = 3;

endpackage

// File: rtl/sync_ff.sv
// Purpose: WIDTH-bit multi-flop synchroniser for asynchronous active-low strobes.
// Latency: STAGES clk edges from input to q.
// Backpressure: none; free-running, resets to all ones (strobes inactive).
// Ports: clk, rst (async active-low), d (async input), q (synchronised output).
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage <= '1;
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/cpu_bus_sync.sv
// Purpose: synchronise async CPU strobes, decode address to one-hot selects, hold reg1..reg3.
// Latency: outputs registered; access visible SYNC_STAGES edges after strobe first sampled low.
// Backpressure: none; CPU holds strobes, RECOVER swallows long strobes so each write pulses once.
// Ports: clk, rst (async active-low); cpu_cs_n/cpu_rd_n/cpu_wr_n/cpu_addr/cpu_din from the CPU;
//        my_rd, my_wr, CS_reg1..3, reg1..3 to the read-back mux; bus_err on rd+wr overlap.
module cpu_bus_sync
  import cpu_bus_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [ADDR_W-1:0] REG1_ADDR   = ADDR_W'(DEF_REG1_ADDR),
  parameter logic [ADDR_W-1:0] REG2_ADDR   = ADDR_W'(DEF_REG2_ADDR),
  parameter logic [ADDR_W-1:0] REG3_ADDR   = ADDR_W'(DEF_REG3_ADDR),
  parameter logic [7:0]        REG_RST_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cs_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              my_rd,
  output logic              my_wr,
  output logic              CS_reg1,
  output logic              CS_reg2,
  output logic              CS_reg3,
  output logic [7:0]        reg1,
  output logic [7:0]        reg2,
  output logic [7:0]        reg3,
  output logic              bus_err
);

  localparam int CW = $clog2(SYNC_STAGES + 1);

  logic [2:0]        sync_q;
  logic              cs, rd, wr;
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, dec_addr;
  logic [7:0]        din_q;
  logic              latch_addr, latch_din;
  logic              my_rd_nxt, my_wr_nxt, bus_err_nxt;
  logic [2:0]        cs_nxt;
  logic [CW-1:0]     settle_cnt;
  logic              settled;

  sync_ff #(
    .WIDTH  (3),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({cpu_cs_n, cpu_rd_n, cpu_wr_n}),
    .q   (sync_q)
  );

  assign cs = !sync_q[2];
  assign rd = !sync_q[1];
  assign wr = !sync_q[0];

  // The synchroniser resets to "inactive", so right after reset it reports idle strobes
  // even if the CPU is mid-access. Hold RECOVER until the synchroniser reflects the real pins.
  assign settled = (settle_cnt == CW'(SYNC_STAGES));

  always_comb begin
    state_nxt   = state;
    latch_addr  = 1'b0;
    latch_din   = 1'b0;
    bus_err_nxt = 1'b0;
    dec_addr    = addr_q;
    case (state)
      IDLE: begin
        if (cs && wr && !rd) begin
          state_nxt  = WRITE;
          latch_addr = 1'b1;
          latch_din  = 1'b1;
          dec_addr   = cpu_addr;
        end else if (cs && rd && !wr) begin
          state_nxt  = READ;
          latch_addr = 1'b1;
          dec_addr   = cpu_addr;
        end else if (cs && rd && wr) begin
          state_nxt   = RECOVER;
          bus_err_nxt = 1'b1;
        end
      end
      WRITE:   state_nxt = RECOVER;
      READ:    if (!(cs && rd)) state_nxt = IDLE;
      RECOVER: if (settled && !cs && !rd && !wr) state_nxt = IDLE;
      default: state_nxt = RECOVER;
    endcase

    // Moore outputs: registered from the state being entered.
    my_wr_nxt = (state_nxt == WRITE);
    my_rd_nxt = (state_nxt == READ);
    cs_nxt    = 3'b000;
    if (my_wr_nxt || my_rd_nxt) begin
      cs_nxt = {dec_addr == REG3_ADDR, dec_addr == REG2_ADDR, dec_addr == REG1_ADDR};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RECOVER;
      settle_cnt <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      my_rd      <= 1'b0;
      my_wr      <= 1'b0;
      CS_reg1    <= 1'b0;
      CS_reg2    <= 1'b0;
      CS_reg3    <= 1'b0;
      bus_err    <= 1'b0;
      reg1       <= REG_RST_VAL;
      reg2       <= REG_RST_VAL;
      reg3       <= REG_RST_VAL;
    end else begin
      state   <= state_nxt;
      my_rd   <= my_rd_nxt;
      my_wr   <= my_wr_nxt;
      CS_reg1 <= cs_nxt[0];
      CS_reg2 <= cs_nxt[1];
      CS_reg3 <= cs_nxt[2];
      bus_err <= bus_err_nxt;
      if (!settled) settle_cnt <= settle_cnt + CW'(1);
      if (latch_addr) addr_q <= cpu_addr;
      if (latch_din)  din_q  <= cpu_din;
      // Register load happens on the edge leaving WRITE; unmapped addresses load nothing.
      if (state == WRITE) begin
        if (addr_q == REG1_ADDR) reg1 <= din_q;
        if (addr_q == REG2_ADDR) reg2 <= din_q;
        if (addr_q == REG3_ADDR) reg3 <= din_q;
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_sync.sv
// Purpose: self-checking bench for cpu_bus_sync using an access-level timing model.
// Latency: model expects outputs 2 edges after the strobe is first sampled low.
// Backpressure: n/a.
module tb_cpu_bus_sync;

  localparam int MAXC = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_cs_n, cpu_rd_n, cpu_wr_n;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_din;
  logic       my_rd, my_wr, CS_reg1, CS_reg2, CS_reg3, bus_err;
  logic [7:0] reg1, reg2, reg3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_pulses = 0;
  int rd_cycles = 0;
  int err_pulses = 0;

  // Expected output per clock edge index, filled in when an access is issued.
  bit       exp_wr  [MAXC];
  bit       exp_rd  [MAXC];
  bit       exp_err [MAXC];
  bit [2:0] exp_cs  [MAXC];
  bit       upd_vld [MAXC];
  int       upd_idx [MAXC];
  bit [7:0] upd_val [MAXC];
  bit [7:0] m_reg   [1:3];

  cpu_bus_sync dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_cs_n (cpu_cs_n),
    .cpu_rd_n (cpu_rd_n),
    .cpu_wr_n (cpu_wr_n),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .my_rd    (my_rd),
    .my_wr    (my_wr),
    .CS_reg1  (CS_reg1),
    .CS_reg2  (CS_reg2),
    .CS_reg3  (CS_reg3),
    .reg1     (reg1),
    .reg2     (reg2),
    .reg3     (reg3),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit [2:0] onehot(input logic [3:0] a);
    case (a)
      4'd1:    return 3'b001;
      4'd2:    return 3'b010;
      4'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Per-cycle compare against the model, sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst !== 1'b1) begin
        m_reg[1] = 8'h00;
        m_reg[2] = 8'h00;
        m_reg[3] = 8'h00;
      end else if (cyc < MAXC && upd_vld[cyc]) begin
        m_reg[upd_idx[cyc]] = upd_val[cyc];
      end
      if (cyc < MAXC) begin
        check("my_wr",   my_wr,   exp_wr[cyc]);
        check("my_rd",   my_rd,   exp_rd[cyc]);
        check("bus_err", bus_err, exp_err[cyc]);
        check("cs_regs", {CS_reg3, CS_reg2, CS_reg1}, exp_cs[cyc]);
        check("reg1", reg1, m_reg[1]);
        check("reg2", reg2, m_reg[2]);
        check("reg3", reg3, m_reg[3]);
      end
      if (my_wr === 1'b1)   wr_pulses++;
      if (my_rd === 1'b1)   rd_cycles++;
      if (bus_err === 1'b1) err_pulses++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobes change on negedge, so the next rising edge (e0) is the first to sample them.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int len);
    int e0;
    cpu_addr = a;
    cpu_din  = d;
    cpu_cs_n = 1'b0;
    cpu_wr_n = 1'b0;
    e0 = cyc + 1;
    exp_wr[e0 + 2] = 1'b1;
    exp_cs[e0 + 2] = onehot(a);
    if (onehot(a) != 3'b000) begin
      upd_vld[e0 + 3] = 1'b1;
      upd_idx[e0 + 3] = int'(a);
      upd_val[e0 + 3] = d;
    end
    idle(len);
    cpu_cs_n = 1'b1;
    cpu_wr_n = 1'b1;
    idle(5);
  endtask

  task automatic do_read(input logic [3:0] a, input int len);
    int e0;
    cpu_addr = a;
    cpu_cs_n = 1'b0;
    cpu_rd_n = 1'b0;
    e0 = cyc + 1;
    for (int k = e0 + 2; k < e0 + len + 2; k++) begin
      exp_rd[k] = 1'b1;
      exp_cs[k] = onehot(a);
    end
    idle(len);
    cpu_cs_n = 1'b1;
    cpu_rd_n = 1'b1;
    idle(5);
  endtask

  task automatic do_error(input logic [3:0] a, input logic [7:0] d, input int len);
    int e0;
    cpu_addr = a;
    cpu_din  = d;
    cpu_cs_n = 1'b0;
    cpu_rd_n = 1'b0;
    cpu_wr_n = 1'b0;
    e0 = cyc + 1;
    exp_err[e0 + 2] = 1'b1;
    idle(len);
    cpu_cs_n = 1'b1;
    cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1;
    idle(5);
  endtask

  initial begin
    int w0, r0, x0;
    rst      = 1'b0;
    cpu_cs_n = 1'b1;
    cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1;
    cpu_addr = 4'd0;
    cpu_din  = 8'h00;
    idle(2);
    check("rst_reg1", reg1, 8'h00);
    check("rst_reg2", reg2, 8'h00);
    check("rst_reg3", reg3, 8'h00);
    check("rst_outs", {my_rd, my_wr, CS_reg1, CS_reg2, CS_reg3, bus_err}, 6'b0);
    rst = 1'b1;
    idle(6);

    // 1: write A5 to reg2
    w0 = wr_pulses;
    do_write(4'd2, 8'hA5, 5);
    check("t1_wr_pulses", wr_pulses - w0, 1);
    check("t1_reg2", reg2, 8'hA5);
    check("t1_reg1", reg1, 8'h00);
    check("t1_reg3", reg3, 8'h00);

    // 2: read reg3, strobe low 6 clocks
    w0 = wr_pulses;
    r0 = rd_cycles;
    do_read(4'd3, 6);
    check("t2_rd_cycles", rd_cycles - r0, 6);
    check("t2_wr_pulses", wr_pulses - w0, 0);

    // 3: long write holds wr_n low 50 clocks
    w0 = wr_pulses;
    do_write(4'd1, 8'h3C, 50);
    check("t3_wr_pulses", wr_pulses - w0, 1);
    check("t3_reg1", reg1, 8'h3C);

    // 4: unmapped write
    w0 = wr_pulses;
    do_write(4'd0, 8'hFF, 5);
    check("t4_wr_pulses", wr_pulses - w0, 1);
    check("t4_regs", {reg1, reg2, reg3}, {8'h3C, 8'hA5, 8'h00});

    // 5: rd and wr together
    w0 = wr_pulses;
    r0 = rd_cycles;
    x0 = err_pulses;
    do_error(4'd3, 8'h11, 5);
    check("t5_err_pulses", err_pulses - x0, 1);
    check("t5_wr_pulses", wr_pulses - w0, 0);
    check("t5_rd_cycles", rd_cycles - r0, 0);
    check("t5_regs", {reg1, reg2, reg3}, {8'h3C, 8'hA5, 8'h00});

    // 6: reset while a write is in flight, release with wr_n still low
    w0 = wr_pulses;
    cpu_addr = 4'd2;
    cpu_din  = 8'h77;
    cpu_cs_n = 1'b0;
    cpu_wr_n = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(10);
    cpu_cs_n = 1'b1;
    cpu_wr_n = 1'b1;
    idle(6);
    check("t6_wr_pulses", wr_pulses - w0, 0);
    check("t6_reg2", reg2, 8'h00);
    check("t6_reg1", reg1, 8'h00);
    w0 = wr_pulses;
    do_write(4'd2, 8'h77, 4);
    check("t6_clean_pulses", wr_pulses - w0, 1);
    check("t6_clean_reg2", reg2, 8'h77);

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
